// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, register-number width and the
// immediate-encoder state encoding.
package mips_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // Encoder state encoding (kept as fixed constants for legacy tools)
    typedef logic [1:0] enc_state_t;
    localparam enc_state_t ST_IDLE     = 2'd0;
    localparam enc_state_t ST_EMIT_ONE = 2'd1;
    localparam enc_state_t ST_EMIT_HI  = 2'd2;
    localparam enc_state_t ST_EMIT_LO  = 2'd3;

    // I-type word builder: {opcode, rs, rt, imm}
    function automatic logic [31:0] itype(input logic [5:0] op,
                                          input logic [REG_W-1:0] rs,
                                          input logic [REG_W-1:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/imm_encoder_fit_check.sv
// imm_fit_check: a 32-bit value fits a sign-extended 16-bit immediate when
// bits [31:15] are all zeros or all ones.
module imm_fit_check (
    input  logic [31:0] In,
    output logic        Fits
);

    // Truncate-and-resign-extend survives only if the upper 17 bits agree
    always_comb begin
        Fits = (In[31:15] == '0) || (In[31:15] == '1);
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: turns a 32-bit constant plus destination register into the
// shortest MIPS sequence (ADDIU, or LUI+ORI) with valid/ready on both sides.
// Optional macro IMM_ENCODER_SKIP_ORI_EN: drop the ORI when its immediate is 0.
module imm_encoder
    import mips_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [31:0]       In_Value,
    input  logic [REG_W-1:0]  In_Rt,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [31:0]       Out_Instr,
    output logic              Out_Last,
    output logic              Busy
);

    enc_state_t  state;
    logic        fits;
    logic [31:0] addiu_word;
    logic [31:0] lui_word;
    logic [31:0] ori_word;
    logic [31:0] ori_pending;
    logic        skip_ori;
    logic        out_hs;

    imm_fit_check u_fit (
        .In   (In_Value),
        .Fits (fits)
    );

    // Candidate words built from the live request; only used at input handshake
    always_comb begin
        addiu_word = itype(OP_ADDIU, '0, In_Rt, In_Value[15:0]);
        lui_word   = itype(OP_LUI, '0, In_Rt, In_Value[31:16]);
        ori_word   = itype(OP_ORI, In_Rt, In_Rt, In_Value[15:0]);
`ifdef IMM_ENCODER_SKIP_ORI_EN
        skip_ori   = (In_Value[15:0] == '0);
`else
        skip_ori   = 1'b0;
`endif
    end

    // Handshake and status decode from registered state
    always_comb begin
        In_Ready = (state == ST_IDLE);
        Busy     = (state != ST_IDLE);
        out_hs   = Out_Valid && Out_Ready;
    end

    // FSM plus output register; the ORI word is prebuilt at input handshake so
    // value and rt need not be held separately
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= ST_IDLE;
            Out_Valid   <= 1'b0;
            Out_Instr   <= '0;
            Out_Last    <= 1'b0;
            ori_pending <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (In_Valid) begin
                        Out_Valid <= 1'b1;
                        if (fits) begin
                            Out_Instr <= addiu_word;
                            Out_Last  <= 1'b1;
                            state     <= ST_EMIT_ONE;
                        end else if (skip_ori) begin
                            Out_Instr <= lui_word;
                            Out_Last  <= 1'b1;
                            state     <= ST_EMIT_ONE;
                        end else begin
                            Out_Instr   <= lui_word;
                            Out_Last    <= 1'b0;
                            ori_pending <= ori_word;
                            state       <= ST_EMIT_HI;
                        end
                    end
                end
                ST_EMIT_HI: begin
                    if (out_hs) begin
                        Out_Instr <= ori_pending;
                        Out_Last  <= 1'b1;
                        state     <= ST_EMIT_LO;
                    end
                end
                ST_EMIT_ONE, ST_EMIT_LO: begin
                    if (out_hs) begin
                        Out_Valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    Out_Valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: the driver pushes expected words, the
// monitor pops and compares on every output handshake.
module tb_imm_encoder;

    logic        Clk;
    logic        Rst;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] In_Value;
    logic [4:0]  In_Rt;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Instr;
    logic        Out_Last;
    logic        Busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [32:0] exp_q[$];   // {last, instr}

    imm_encoder dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .In_Value  (In_Value),
        .In_Rt     (In_Rt),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Instr (Out_Instr),
        .Out_Last  (Out_Last),
        .Busy      (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: capture at negedge when a handshake is pending, compare against queue
    initial begin
        logic [31:0] cap_instr;
        logic        cap_last;
        logic [32:0] e;
        forever begin
            @(negedge Clk);
            if (Out_Valid === 1'b1 && Out_Ready === 1'b1 && Rst === 1'b0) begin
                cap_instr = Out_Instr;
                cap_last  = Out_Last;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h last %0d expected none", cap_instr, cap_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_instr", cap_instr, e[31:0]);
                    chk("out_last", {31'd0, cap_last}, {31'd0, e[32]});
                end
            end
        end
    end

    // Issue one request; caller has already pushed its expectations
    task automatic send(input logic [31:0] value, input logic [4:0] rt);
        int n;
        @(posedge Clk);
        #1;
        In_Valid = 1'b1;
        In_Value = value;
        In_Rt    = rt;
        n = 0;
        while (In_Ready !== 1'b1 && n < 50) begin
            @(posedge Clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        In_Value = 32'hDEAD_BEEF;   // later input changes must be ignored
        In_Rt    = 5'd31;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || Busy !== 1'b0) && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk({name, "_drained"}, {31'd0, (n < 100)}, 32'd1);
        chk({name, "_in_ready"}, {31'd0, In_Ready}, 32'd1);
    endtask

    task automatic push(input logic [31:0] w, input logic last);
        exp_q.push_back({last, w});
    endtask

    // Directed fit/no-fit vectors
    typedef struct {
        logic [31:0] value;
        logic [4:0]  rt;
        logic [31:0] w0;
        logic        two;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{32'hFFFF_FFFF, 5'd8,  32'h2408_FFFF, 1'b0, 32'h0};
        vecs[1] = '{32'hFFFF_AAAA, 5'd9,  32'h2409_AAAA, 1'b0, 32'h0};
        vecs[2] = '{32'h0001_2345, 5'd8,  32'h3C08_0001, 1'b1, 32'h3508_2345};
        vecs[3] = '{32'h0000_8000, 5'd8,  32'h3C08_0000, 1'b1, 32'h3508_8000};
        vecs[4] = '{32'h0000_7FFF, 5'd0,  32'h2400_7FFF, 1'b0, 32'h0};
        vecs[5] = '{32'hFFFF_8000, 5'd31, 32'h241F_8000, 1'b0, 32'h0};

        Rst       = 1'b1;
        In_Valid  = 1'b0;
        In_Value  = '0;
        In_Rt     = '0;
        Out_Ready = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("rst_out_instr", Out_Instr, 32'h0);
        chk("rst_out_last", {31'd0, Out_Last}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;

        foreach (vecs[i]) begin
            push(vecs[i].w0, !vecs[i].two);
            if (vecs[i].two) push(vecs[i].w1, 1'b1);
            send(vecs[i].value, vecs[i].rt);
            drain("vec");
        end

        // Back-to-back requests without draining in between
        push(32'h2408_FFFF, 1'b1);
        send(32'hFFFF_FFFF, 5'd8);
        push(32'h3C08_0001, 1'b0);
        push(32'h3508_2345, 1'b1);
        send(32'h0001_2345, 5'd8);
        drain("b2b");

        // Zero-immediate ORI, with and without the skip option
`ifdef IMM_ENCODER_SKIP_ORI_EN
        push(32'h3C08_1234, 1'b1);
`else
        push(32'h3C08_1234, 1'b0);
        push(32'h3508_0000, 1'b1);
`endif
        send(32'h1234_0000, 5'd8);
        drain("zero_lo");

        // Backpressure on the LUI
        @(posedge Clk);
        #1;
        Out_Ready = 1'b0;
        push(32'h3C08_0001, 1'b0);
        push(32'h3508_2345, 1'b1);
        send(32'h0001_2345, 5'd8);
        n = 0;
        while (Out_Valid !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("bp_valid_seen", {31'd0, Out_Valid}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("bp_instr_stable", Out_Instr, 32'h3C08_0001);
            chk("bp_last_stable", {31'd0, Out_Last}, 32'd0);
            chk("bp_in_ready", {31'd0, In_Ready}, 32'd0);
            chk("bp_busy", {31'd0, Busy}, 32'd1);
        end
        @(posedge Clk);
        #1;
        Out_Ready = 1'b1;
        @(posedge Clk);   // LUI handshake
        #1;
        chk("bp_ori_valid", {31'd0, Out_Valid}, 32'd1);
        chk("bp_ori_word", Out_Instr, 32'h3508_2345);
        drain("bp");

        // Reset right after the LUI handshake discards the pending ORI
        @(posedge Clk);
        #1;
        Out_Ready = 1'b0;
        push(32'h3C08_0001, 1'b0);
        send(32'h0001_2345, 5'd8);
        n = 0;
        while (Out_Valid !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("rm_valid_seen", {31'd0, Out_Valid}, 32'd1);
        @(posedge Clk);
        #1;
        Out_Ready = 1'b1;
        @(posedge Clk);   // LUI handshake
        #1;
        Rst = 1'b1;
        #1;
        chk("rm_out_valid", {31'd0, Out_Valid}, 32'd0);
        chk("rm_out_instr", Out_Instr, 32'h0);
        chk("rm_in_ready", {31'd0, In_Ready}, 32'd1);
        chk("rm_busy", {31'd0, Busy}, 32'd0);
        chk("rm_queue_empty", exp_q.size(), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rm_no_ori", {31'd0, Out_Valid}, 32'd0);

        // Accepting resumes after reset
        push(32'hFFFF_AAAA & 32'h0 | 32'h2409_AAAA, 1'b1);
        send(32'hFFFF_AAAA, 5'd9);
        drain("post_rst");

        repeat (2) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
